// File: rtl/prng_pool.sv
// prng_pool
// ---------
// A pool of independent random-word generators. Each channel runs its own
// Galois LFSR. The LFSR steps one bit per cycle into a shift register until
// OUTPUT_BITS bits are collected. The finished word is then held, with valid
// high, until the consumer acknowledges it with taken. An external entropy bit
// can be folded into the top of each LFSR on every step.
//
// Parameters
//   CHANNELS    number of independent channels (1..16)
//   LFSR_BITS   width of each channel's LFSR (4..64)
//   OUTPUT_BITS width of each delivered word (2..128)
//   POLYNOMIAL  Galois feedback mask, LFSR_BITS wide
//   SEED        base seed, LFSR_BITS wide; each channel derives its own from it
//
// Ports
//   clk      clock, all state changes on the rising edge
//   rst      asynchronous active-high reset
//   entropy  per-channel entropy bit, mixed in only while that channel fills
//   reseed   synchronous pulse: restart every channel from its seed
//   taken    per-channel acknowledge, honoured only while valid is high
//   valid    per-channel word-available flag
//   random   packed words, channel c at [c*OUTPUT_BITS +: OUTPUT_BITS]

module prng_pool #(
   parameter int                   CHANNELS    = 4,
   parameter int                   LFSR_BITS   = 32,
   parameter int                   OUTPUT_BITS = 32,
   parameter logic [LFSR_BITS-1:0] POLYNOMIAL  = 32'h8020_0003,
   parameter logic [LFSR_BITS-1:0] SEED        = 32'h1234_5678
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [CHANNELS-1:0]             entropy,
   input  logic                            reseed,
   input  logic [CHANNELS-1:0]             taken,
   output logic [CHANNELS-1:0]             valid,
   output logic [CHANNELS*OUTPUT_BITS-1:0] random
);

   localparam int CNT_W = $clog2(OUTPUT_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUTPUT_BITS - 1);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Channel seeds are spread with a golden-ratio multiplier so that
   // neighbouring channels start far apart. An all-zero seed would lock the
   // LFSR, so the polynomial is used in its place.
   function automatic logic [LFSR_BITS-1:0] chan_seed(input int idx);
      logic [LFSR_BITS-1:0] mix;
      logic [LFSR_BITS-1:0] s;
      mix = LFSR_BITS'(64'(idx) * 64'h0000_0000_9E37_79B9);
      s   = SEED ^ mix;
      return (s == '0) ? POLYNOMIAL : s;
   endfunction

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      localparam logic [LFSR_BITS-1:0] SEED_C = chan_seed(c);

      state_t                 state_q, state_d;
      logic [LFSR_BITS-1:0]   lfsr_q, lfsr_d;
      logic [LFSR_BITS-1:0]   step;
      logic [OUTPUT_BITS-1:0] word_q, word_d;
      logic [CNT_W-1:0]       cnt_q, cnt_d;

      always_comb begin
         state_d = state_q;
         lfsr_d  = lfsr_q;
         word_d  = word_q;
         cnt_d   = cnt_q;

         step = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLYNOMIAL : '0);
         step[LFSR_BITS-1] = step[LFSR_BITS-1] ^ entropy[c];

         if (reseed) begin
            // Reseed wins over both stepping and acknowledge; held words are lost.
            state_d = FILL;
            lfsr_d  = SEED_C;
            word_d  = '0;
            cnt_d   = '0;
         end else begin
            unique case (state_q)
               FILL: begin
                  // Entropy can cancel the feedback and zero the register;
                  // restart from the seed rather than lock up.
                  lfsr_d = (step == '0) ? SEED_C : step;
                  word_d = {word_q[OUTPUT_BITS-2:0], lfsr_q[0]};
                  if (cnt_q == CNT_LAST) begin
                     state_d = HOLD;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
               HOLD: begin
                  if (taken[c]) begin
                     state_d = FILL;
                     cnt_d   = '0;
                  end
               end
               default: state_d = FILL;
            endcase
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= FILL;
            lfsr_q  <= SEED_C;
            word_q  <= '0;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
         end
      end

      assign valid[c] = (state_q == HOLD);
      assign random[c*OUTPUT_BITS +: OUTPUT_BITS] = word_q;
   end

endmodule
